load_store_byte_sequencer: RTL and testbench

Memory-stage sequencer between the load/store pipeline and the byte-wide data memory (`MEM_DATA_BUS_WIDTH`=8, combinational read, write on posedge when enabled). Accepts one 32-bit word or byte load/store request at a time and issues it as 1 or 4 consecutive byte beats, little-endian. Assembles load data and returns a single-cycle completion response. The pipeline stalls on `req_ready_out`=0.

---
 rtl/load_store_byte_sequencer_pkg.sv | 24 ++
 rtl/load_store_byte_sequencer_lane_mux.sv | 23 ++
 rtl/load_store_byte_sequencer.sv | 135 +++++++++++++
 tb/tb_load_store_byte_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_byte_sequencer_pkg.sv
// Shared constants and types for the load/store byte sequencer.
// These are the bus widths, the FSM state encodings and the last-beat indices.
package load_store_byte_sequencer_pkg;

  localparam int ADDR_BUS_WIDTH     = 32;
  localparam int MEM_DATA_BUS_WIDTH = 8;
  localparam int REG_DATA_WIDTH     = 4 * MEM_DATA_BUS_WIDTH;
  localparam int BEAT_W             = 2;

  localparam logic [BEAT_W-1:0] LS_LAST_BEAT_WORD = 2'd3;
  localparam logic [BEAT_W-1:0] LS_LAST_BEAT_BYTE = 2'd0;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_BEAT = 2'd1,
    LS_DONE = 2'd2
  } ls_state_e;

  // Index of the final beat for a request of the given size.
  function automatic logic [BEAT_W-1:0] last_beat(input logic is_byte);
    return is_byte ? LS_LAST_BEAT_BYTE : LS_LAST_BEAT_WORD;
  endfunction

endpackage

// File: rtl/load_store_byte_sequencer_lane_mux.sv
// ls_byte_lane_mux: picks the store byte for the current beat and merges
// the returning load byte into its little-endian lane of the assembly word.
module ls_byte_lane_mux
  import load_store_byte_sequencer_pkg::*;
(
  input  logic [BEAT_W-1:0]             beat,
  input  logic [REG_DATA_WIDTH-1:0]     wdata,
  output logic [MEM_DATA_BUS_WIDTH-1:0] store_byte,
  input  logic [REG_DATA_WIDTH-1:0]     asm_cur,
  input  logic [MEM_DATA_BUS_WIDTH-1:0] load_byte,
  output logic [REG_DATA_WIDTH-1:0]     asm_next
);

  // Byte-lane select for stores and lane insert for loads.
  always_comb begin
    // NOTE: every output gets a full default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    asm_next   = asm_cur;
    store_byte = wdata[MEM_DATA_BUS_WIDTH*beat +: MEM_DATA_BUS_WIDTH];
    asm_next[MEM_DATA_BUS_WIDTH*beat +: MEM_DATA_BUS_WIDTH] = load_byte;
  end

endmodule

// File: rtl/load_store_byte_sequencer.sv
// load_store_byte_sequencer: issues one word or byte load/store as 1 or 4
// little-endian byte beats to a byte-wide memory and returns a one-cycle
// completion response.
// Optional feature: define LS_ALIGN_CHECK_EN to reject misaligned word
// requests with rsp_fault_out instead of running them unaligned.
module load_store_byte_sequencer
  import load_store_byte_sequencer_pkg::*;
(
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic                          req_valid_in,
  output logic                          req_ready_out,
  input  logic                          req_load_in,
  input  logic                          req_byte_in,
  input  logic [ADDR_BUS_WIDTH-1:0]     addr_in,
  input  logic [REG_DATA_WIDTH-1:0]     wdata_in,
  output logic                          rsp_valid_out,
  output logic [REG_DATA_WIDTH-1:0]     rsp_rdata_out,
  output logic                          rsp_fault_out,
  output logic [ADDR_BUS_WIDTH-1:0]     mem_addr_out,
  output logic                          mem_we_out,
  output logic [MEM_DATA_BUS_WIDTH-1:0] mem_wd_out,
  input  logic [MEM_DATA_BUS_WIDTH-1:0] mem_rd_in
);

  ls_state_e                     state_q, state_d;
  logic [BEAT_W-1:0]             beat_q;
  logic [ADDR_BUS_WIDTH-1:0]     addr_q;
  logic [REG_DATA_WIDTH-1:0]     wdata_q;
  logic                          load_q;
  logic                          byte_q;
  logic [REG_DATA_WIDTH-1:0]     asm_q;
  logic [REG_DATA_WIDTH-1:0]     asm_next;
  logic [MEM_DATA_BUS_WIDTH-1:0] store_byte;
  logic                          fault_w;
  logic                          misaligned_w;

  assign misaligned_w = !req_byte_in && (addr_in[1:0] != 2'b00);

`ifdef LS_ALIGN_CHECK_EN
  logic fault_q;

  // Remember whether the accepted request was rejected for misalignment.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      fault_q <= 1'b0;
    end else if (state_q == LS_IDLE && req_valid_in) begin
      fault_q <= misaligned_w;
    end
  end

  assign fault_w = fault_q;
`else
  assign fault_w = 1'b0;
`endif

  ls_byte_lane_mux u_lane_mux (
    .beat       (beat_q),
    .wdata      (wdata_q),
    .store_byte (store_byte),
    .asm_cur    (asm_q),
    .load_byte  (mem_rd_in),
    .asm_next   (asm_next)
  );

  // Request capture, beat counter, load assembly and state register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_in) begin
      state_q <= LS_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      byte_q  <= 1'b0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LS_IDLE: if (req_valid_in) begin
          addr_q  <= addr_in;
          wdata_q <= wdata_in;
          load_q  <= req_load_in;
          byte_q  <= req_byte_in;
          beat_q  <= '0;
          asm_q   <= '0;
        end
        LS_BEAT: begin
          if (load_q) asm_q <= asm_next;
          if (beat_q != last_beat(byte_q)) beat_q <= beat_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic and Moore outputs; everything idles at zero outside its state.
  always_comb begin
    state_d       = state_q;
    req_ready_out = 1'b0;
    rsp_valid_out = 1'b0;
    rsp_rdata_out = '0;
    rsp_fault_out = 1'b0;
    mem_addr_out  = '0;
    mem_we_out    = 1'b0;
    mem_wd_out    = '0;
    case (state_q)
      LS_IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
`ifdef LS_ALIGN_CHECK_EN
          state_d = misaligned_w ? LS_DONE : LS_BEAT;
`else
          state_d = LS_BEAT;
`endif
        end
      end
      LS_BEAT: begin
        mem_addr_out = addr_q + ADDR_BUS_WIDTH'(beat_q);
        mem_we_out   = !load_q;
        mem_wd_out   = load_q ? '0 : store_byte;
        if (beat_q == last_beat(byte_q)) state_d = LS_DONE;
      end
      LS_DONE: begin
        rsp_valid_out = 1'b1;
        rsp_fault_out = fault_w;
        rsp_rdata_out = (load_q && !fault_w) ? asm_q : '0;
        state_d       = LS_IDLE;
      end
      default: state_d = LS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_byte_sequencer.sv
// Self-checking bench for load_store_byte_sequencer with a 256-byte memory
// model (address bits [7:0]) and a response scoreboard.
module tb_load_store_byte_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_load_in;
  logic        req_byte_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        rsp_valid_out;
  logic [31:0] rsp_rdata_out;
  logic        rsp_fault_out;
  logic [31:0] mem_addr_out;
  logic        mem_we_out;
  logic [7:0]  mem_wd_out;
  logic [7:0]  mem_rd_in;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } rsp_t;

  rsp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem [0:255];
  logic       mem_clear;

  always #5 clk_in = ~clk_in;

  load_store_byte_sequencer dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_load_in   (req_load_in),
    .req_byte_in   (req_byte_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_rdata_out (rsp_rdata_out),
    .rsp_fault_out (rsp_fault_out),
    .mem_addr_out  (mem_addr_out),
    .mem_we_out    (mem_we_out),
    .mem_wd_out    (mem_wd_out),
    .mem_rd_in     (mem_rd_in)
  );

  assign mem_rd_in = mem[mem_addr_out[7:0]];

  always @(posedge clk_in) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h14] <= 8'h77;
    end else if (mem_we_out) begin
      mem[mem_addr_out[7:0]] <= mem_wd_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Follow one request from the cycle after acceptance until its response.
  task automatic wait_rsp(input logic ld, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_cyc);
    bit   seen = 0;
    rsp_t e;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk_in);
      if (rsp_valid_out) begin
        seen = 1;
        check("rsp_cycle", c, exp_cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_empty observed=response expected=none");
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata_out, e.rdata);
          check("rsp_fault", rsp_fault_out, e.fault);
        end
        check("done_ready", req_ready_out, 0);
        check("done_we", mem_we_out, 0);
        check("done_addr", mem_addr_out, 0);
      end else begin
        check("beat_addr", mem_addr_out, addr + 32'(c - 1));
        check("beat_we", mem_we_out, !ld);
        check("beat_wd", mem_wd_out, ld ? 32'h0 : (wdata >> (8 * (c - 1))) & 32'hFF);
        check("busy_ready", req_ready_out, 0);
        check("quiet_rdata", rsp_rdata_out, 0);
        check("quiet_fault", rsp_fault_out, 0);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL rsp_timeout observed=none expected=response");
    end
    @(negedge clk_in);
    check("post_ready", req_ready_out, 1);
    check("post_valid", rsp_valid_out, 0);
    check("post_we", mem_we_out, 0);
  endtask

  task automatic issue(input logic ld, input logic bt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_fault, input int exp_cyc);
    rsp_t e;
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_load_in  = ld;
    req_byte_in  = bt;
    addr_in      = addr;
    wdata_in     = wdata;
    exp_q.push_back(e);
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    wait_rsp(ld, addr, wdata, exp_cyc);
  endtask

  initial begin
    rsp_t e;
    reset_in     = 1'b0;
    req_valid_in = 1'b0;
    req_load_in  = 1'b0;
    req_byte_in  = 1'b0;
    addr_in      = '0;
    wdata_in     = '0;
    mem_clear    = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    mem_clear = 1'b0;
    check("rst_ready", req_ready_out, 1);
    check("rst_valid", rsp_valid_out, 0);
    check("rst_rdata", rsp_rdata_out, 0);
    check("rst_fault", rsp_fault_out, 0);
    check("rst_addr", mem_addr_out, 0);
    check("rst_we", mem_we_out, 0);
    check("rst_wd", mem_wd_out, 0);
    reset_in = 1'b1;

    // Word store then word load of the same location.
    issue(1'b0, 1'b0, 32'h10, 32'hA1B2C3D4, 32'h0, 1'b0, 5);
    check("mem_10", mem[8'h10], 8'hD4);
    check("mem_11", mem[8'h11], 8'hC3);
    check("mem_12", mem[8'h12], 8'hB2);
    check("mem_13", mem[8'h13], 8'hA1);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 32'hA1B2C3D4, 1'b0, 5);

    // Byte load, then byte store that uses only wdata[7:0].
    issue(1'b1, 1'b1, 32'h12, 32'h0, 32'h000000B2, 1'b0, 2);
    issue(1'b0, 1'b1, 32'h11, 32'hFFFFFF5A, 32'h0, 1'b0, 2);
    check("bst_10", mem[8'h10], 8'hD4);
    check("bst_11", mem[8'h11], 8'h5A);
    check("bst_12", mem[8'h12], 8'hB2);

    // Misaligned word load and wrapping word store.
`ifdef LS_ALIGN_CHECK_EN
    issue(1'b1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b0, 1'b0, 32'hFFFFFFFE, 32'h11223344, 32'h0, 1'b1, 1);
    check("wrap_fe", mem[8'hFE], 8'h00);
    check("wrap_00", mem[8'h00], 8'h00);
`else
    issue(1'b1, 1'b0, 32'h11, 32'h0, 32'h77A1B25A, 1'b0, 5);
    issue(1'b0, 1'b0, 32'hFFFFFFFE, 32'h11223344, 32'h0, 1'b0, 5);
    check("wrap_fe", mem[8'hFE], 8'h44);
    check("wrap_ff", mem[8'hFF], 8'h33);
    check("wrap_00", mem[8'h00], 8'h22);
    check("wrap_01", mem[8'h01], 8'h11);
`endif

    // Back-to-back word loads with req_valid_in held high.
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_load_in  = 1'b1;
    req_byte_in  = 1'b0;
    addr_in      = 32'h10;
    e.rdata      = 32'hA1B25AD4;
    e.fault      = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(posedge clk_in);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      check("b2b_ready", req_ready_out, (c == 6) ? 32'd1 : 32'd0);
      check("b2b_valid", rsp_valid_out, (c == 5) ? 32'd1 : 32'd0);
      if (rsp_valid_out && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("b2b_rdata", rsp_rdata_out, e.rdata);
      end
    end
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    wait_rsp(1'b1, 32'h10, 32'h0, 5);

    // Reset pulled in the second beat of a word store.
    @(negedge clk_in);
    req_valid_in = 1'b1;
    req_load_in  = 1'b0;
    req_byte_in  = 1'b0;
    addr_in      = 32'h20;
    wdata_in     = 32'hCAFEBABE;
    @(posedge clk_in);
    #1 req_valid_in = 1'b0;
    @(negedge clk_in);
    check("rst_mid_we1", mem_we_out, 1);
    @(posedge clk_in);
    #2 reset_in = 1'b0;
    #1;
    check("rst_mid_we", mem_we_out, 0);
    check("rst_mid_ready", req_ready_out, 1);
    check("rst_mid_addr", mem_addr_out, 0);
    @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      check("rst_no_rsp", rsp_valid_out, 0);
    end
    check("rst_mem_20", mem[8'h20], 8'hBE);
    check("rst_mem_21", mem[8'h21], 8'h00);
    check("rst_mem_22", mem[8'h22], 8'h00);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
